// File: rtl/lifo_stack.sv
// LIFO stack, WIDTH x DEPTH, registered top-of-stack; optional sticky err port via STACK_ERR_EN.
// Latency: an operation sampled at edge N is visible on out/count/flags after edge N.
// Backpressure: none; push when full pulses ovf, pop when empty pulses unf, state untouched.
module lifo_stack #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           in,
    output logic [WIDTH-1:0]           out,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       ovf,
`ifdef STACK_ERR_EN
    output logic                       err,
`endif
    output logic                       unf
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_en;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic [CW-1:0]    count_nxt;
    logic [WIDTH-1:0] out_nxt;
    logic             ovf_nxt;
    logic             unf_nxt;

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign rd_idx = AW'(count - CW'(2));

    always_comb begin
        wr_en     = 1'b0;
        wr_idx    = AW'(count);
        count_nxt = count;
        out_nxt   = out;
        ovf_nxt   = 1'b0;
        unf_nxt   = 1'b0;
        if (push && pop && !empty) begin
            // replace-top: legal even when full
            wr_en   = 1'b1;
            wr_idx  = AW'(count - CW'(1));
            out_nxt = in;
        end else if (push && !full) begin
            wr_en     = 1'b1;
            wr_idx    = AW'(count);
            count_nxt = count + CW'(1);
            out_nxt   = in;
        end else if (push) begin
            ovf_nxt = 1'b1;
        end else if (pop && !empty) begin
            count_nxt = count - CW'(1);
            out_nxt   = (count == CW'(1)) ? '0 : mem[rd_idx];
        end else if (pop) begin
            unf_nxt = 1'b1;
        end
    end

    // storage needs no reset: entries above count are never observable
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out   <= '0;
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            out   <= out_nxt;
            count <= count_nxt;
            ovf   <= ovf_nxt;
            unf   <= unf_nxt;
        end
    end

`ifdef STACK_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (ovf_nxt || unf_nxt) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_lifo_stack.sv
// Directed bench for lifo_stack (WIDTH=9, DEPTH=4) with a queue-model scoreboard.
module tb_lifo_stack;
    localparam int W = 9;
    localparam int D = 4;

    typedef struct {
        logic [W-1:0] out;
        int           cnt;
        logic         ovf;
        logic         unf;
        logic         err;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         push = 1'b0;
    logic         pop = 1'b0;
    logic [W-1:0] din = '0;
    logic [W-1:0] out;
    logic [2:0]   count;
    logic         empty, full, ovf, unf;
`ifdef STACK_ERR_EN
    logic         err;
`endif

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] model [$];
    logic         err_m = 1'b0;
    exp_t         sb [$];

    always #5 clk = ~clk;

    lifo_stack #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .in(din),
        .out(out), .count(count), .empty(empty), .full(full), .ovf(ovf),
`ifdef STACK_ERR_EN
        .err(err),
`endif
        .unf(unf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".out"},   32'(out),   32'(e.out));
        chk({tag, ".count"}, 32'(count), 32'(e.cnt));
        chk({tag, ".empty"}, 32'(empty), 32'(e.cnt == 0));
        chk({tag, ".full"},  32'(full),  32'(e.cnt == D));
        chk({tag, ".ovf"},   32'(ovf),   32'(e.ovf));
        chk({tag, ".unf"},   32'(unf),   32'(e.unf));
`ifdef STACK_ERR_EN
        chk({tag, ".err"},   32'(err),   32'(e.err));
`endif
    endtask

    task automatic step(input logic p, input logic q, input logic [W-1:0] d, input string tag);
        exp_t e;
        @(negedge clk);
        push = p; pop = q; din = d;
        e.ovf = 1'b0; e.unf = 1'b0;
        if (p && q && model.size() > 0)  model[model.size()-1] = d;
        else if (p && model.size() < D)  model.push_back(d);
        else if (p)                      e.ovf = 1'b1;
        else if (q && model.size() > 0) void'(model.pop_back());
        else if (q)                      e.unf = 1'b1;
        err_m = err_m | e.ovf | e.unf;
        e.err = err_m;
        e.cnt = model.size();
        e.out = (model.size() > 0) ? model[model.size()-1] : '0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        chk_all(tag, sb.pop_front());
        push = 1'b0; pop = 1'b0;
    endtask

    initial begin
        exp_t r;
        r.out = '0; r.cnt = 0; r.ovf = 1'b0; r.unf = 1'b0; r.err = 1'b0;

        // 1. reset then idle
        repeat (2) @(posedge clk);
        #1 chk_all("reset", r);
        @(negedge clk) rst_n = 1'b1;
        step(0, 0, '0, "idle");

        // 2. fill then drain
        step(1, 0, 9'h101, "push1");
        step(1, 0, 9'h0A2, "push2");
        step(1, 0, 9'h1FF, "push3");
        step(1, 0, 9'h003, "push4");
        chk("full_const", 32'(full), 32'd1);
        step(0, 1, '0, "pop4");
        chk("pop4_const", 32'(out), 32'h1FF);
        step(0, 1, '0, "pop3");
        step(0, 1, '0, "pop2");
        step(0, 1, '0, "pop1");
        chk("drain_const", 32'(out), 32'h000);

        // 3. overflow
        step(1, 0, 9'h101, "refill1");
        step(1, 0, 9'h0A2, "refill2");
        step(1, 0, 9'h1FF, "refill3");
        step(1, 0, 9'h003, "refill4");
        step(1, 0, 9'h055, "ovf");
        chk("ovf_out_const", 32'(out), 32'h003);
        step(0, 0, '0, "ovf_clear");
        step(0, 1, '0, "pop_after_ovf");
        chk("pop_after_ovf_const", 32'(out), 32'h1FF);
        step(0, 1, '0, "drain_a");
        step(0, 1, '0, "drain_b");
        step(0, 1, '0, "drain_c");

        // 4. underflow
        step(0, 1, '0, "unf");
        step(0, 0, '0, "unf_clear");
        step(0, 1, '0, "unf_again");
        step(0, 0, '0, "unf_clear2");

        // 5. replace-top
        step(1, 0, 9'h101, "rp_push1");
        step(1, 0, 9'h0A2, "rp_push2");
        step(1, 1, 9'h077, "replace");
        chk("replace_const", 32'(out), 32'h077);
        step(0, 1, '0, "rp_pop");
        chk("rp_pop_const", 32'(out), 32'h101);
        step(0, 1, '0, "rp_empty");
        step(1, 1, 9'h011, "pushpop_empty");
        chk("pushpop_empty_cnt", 32'(count), 32'd1);
        step(1, 0, 9'h022, "fill_b");
        step(1, 0, 9'h033, "fill_c");
        step(1, 0, 9'h044, "fill_d");
        step(1, 1, 9'h0EE, "replace_full");
        step(0, 1, '0, "to_three");
        step(0, 1, '0, "below_replace");

        // 6. async reset mid-sequence, push in that cycle discarded
        step(1, 0, 9'h0F0, "pre_rst");
        @(negedge clk);
        push = 1'b1; din = 9'h155;
        #2 rst_n = 1'b0;
        #1 chk_all("async_rst", r);
        model.delete();
        err_m = 1'b0;
        @(posedge clk);
        #1 chk_all("rst_held", r);
        @(negedge clk);
        push = 1'b0;
        rst_n = 1'b1;
        step(1, 0, 9'h1AA, "post_rst");
        chk("post_rst_const", 32'(out), 32'h1AA);
        step(0, 0, '0, "final_idle");

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
